ads1299_frame_reader: RTL

- Upstream feeder of the lock-in chain: reads ADS1299 RDATAC frames over SPI on each DRDY.
- Selects one channel, sign-extends 24→32 bits, and emits the sample as a one-cycle valid pulse on x / x_valid.
- Those outputs connect directly to the lock-in wrapper input.
- Also exports the 24-bit status word and error strobes for debug.

---
 rtl/ads1299_pkg.sv | 19 +
 rtl/spi_sclk_gen.sv | 41 ++++
 rtl/ads1299_frame_reader.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ads1299_pkg.sv
// Shared constants, frame-length helper and FSM state encoding for the ADS1299 frame reader.
package ads1299_pkg;

  localparam int ADS_WORD_W = 24;
  localparam logic [3:0] ADS_HEADER_NIBBLE = 4'b1100;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    HOLD   = 3'd3,
    OUTPUT = 3'd4
  } ads_state_e;

  function automatic int frame_bits(input int n_ch);
    return ADS_WORD_W + ADS_WORD_W * n_ch;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: while enabled, sclk idles low for CLK_DIV cycles then toggles every CLK_DIV
// cycles; rise/fall strobe in the cycle whose closing edge moves sclk.
module spi_sclk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             sclk_reg;
  logic             terminal;

  assign terminal = en && (cnt_reg == CNT_LAST);
  assign rise     = terminal && !sclk_reg;
  assign fall     = terminal && sclk_reg;
  assign sclk     = sclk_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b0;
    end else if (!en) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b0;
    end else if (terminal) begin
      cnt_reg  <= '0;
      sclk_reg <= !sclk_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ads1299_frame_reader.sv
// Reads ADS1299 RDATAC frames on each DRDY and emits the selected channel as a sign-extended sample.
// Optional header check enabled by defining ADS_HEADER_CHECK_EN.
module ads1299_frame_reader
  import ads1299_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int N_CH    = 8,
  parameter int Q_OUT   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             drdy_n,
  input  logic             dout,
  input  logic [2:0]       ch_sel,
  output logic             cs_n,
  output logic             sclk,
  output logic [Q_OUT-1:0] x,
  output logic             x_valid,
  output logic [23:0]      status,
  output logic             frame_err,
  output logic             overrun
);

  localparam int FRAME_BITS = frame_bits(N_CH);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int HOLD_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0]  HDR_END   = BIT_W'(ADS_WORD_W);
  localparam logic [BIT_W-1:0]  FRAME_END = BIT_W'(FRAME_BITS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLK_DIV - 1);

  logic drdy_meta_reg, drdy_sync_reg, drdy_prev_reg;
  logic dout_meta_reg, dout_sync_reg;
  logic drdy_fall;

  ads_state_e              state_reg;
  logic [BIT_W-1:0]        bit_cnt_reg;
  logic [BIT_W-1:0]        bit_cnt_next;
  logic [BIT_W-1:0]        chan_end;
  logic [HOLD_W-1:0]       hold_cnt_reg;
  logic [ADS_WORD_W-1:0]   shift_reg;
  logic [ADS_WORD_W-1:0]   shift_next;
  logic [ADS_WORD_W-1:0]   header_reg;
  logic [ADS_WORD_W-1:0]   chan_reg;
  logic [2:0]              ch_reg;
  logic [2:0]              ch_clamped;
  logic                    cs_n_reg;
  logic [Q_OUT-1:0]        x_reg;
  logic                    x_valid_reg;
  logic [23:0]             status_reg;
  logic                    overrun_reg;
  logic                    hdr_ok;
  logic                    gen_en;
  logic                    sclk_rise;
  logic                    sclk_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drdy_meta_reg <= 1'b1;
      drdy_sync_reg <= 1'b1;
      drdy_prev_reg <= 1'b1;
      dout_meta_reg <= 1'b0;
      dout_sync_reg <= 1'b0;
    end else begin
      drdy_meta_reg <= drdy_n;
      drdy_sync_reg <= drdy_meta_reg;
      drdy_prev_reg <= drdy_sync_reg;
      dout_meta_reg <= dout;
      dout_sync_reg <= dout_meta_reg;
    end
  end

  assign drdy_fall    = drdy_prev_reg && !drdy_sync_reg;
  assign gen_en       = (state_reg == SETUP) || (state_reg == SHIFT);
  assign shift_next   = {shift_reg[ADS_WORD_W-2:0], dout_sync_reg};
  assign bit_cnt_next = bit_cnt_reg + 1'b1;
  assign ch_clamped   = (int'(ch_sel) >= N_CH) ? 3'(N_CH - 1) : ch_sel;
  // Channel k ends (k+2) words into the frame: one header word plus k+1 channel words.
  assign chan_end     = BIT_W'((int'(ch_reg) + 2) * ADS_WORD_W);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (gen_en),
    .sclk    (sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      shift_reg    <= '0;
      header_reg   <= '0;
      chan_reg     <= '0;
      ch_reg       <= '0;
      cs_n_reg     <= 1'b1;
      x_reg        <= '0;
      x_valid_reg  <= 1'b0;
      status_reg   <= '0;
      overrun_reg  <= 1'b0;
    end else begin
      x_valid_reg <= 1'b0;
      overrun_reg <= drdy_fall && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (drdy_fall) begin
            state_reg    <= SETUP;
            cs_n_reg     <= 1'b0;
            ch_reg       <= ch_clamped;
            bit_cnt_reg  <= '0;
            hold_cnt_reg <= '0;
          end
        end
        SETUP: begin
          if (sclk_rise) state_reg <= SHIFT;
        end
        SHIFT: begin
          if (sclk_fall) begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            if (bit_cnt_next == HDR_END) header_reg <= shift_next;
            if (bit_cnt_next == chan_end) chan_reg <= shift_next;
            if (bit_cnt_next == FRAME_END) state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            cs_n_reg  <= 1'b1;
            state_reg <= OUTPUT;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        OUTPUT: begin
          status_reg <= header_reg;
          if (hdr_ok) begin
            x_reg       <= {{(Q_OUT - ADS_WORD_W){chan_reg[ADS_WORD_W-1]}}, chan_reg};
            x_valid_reg <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef ADS_HEADER_CHECK_EN
  logic frame_err_reg;

  assign hdr_ok = (header_reg[ADS_WORD_W-1 -: 4] == ADS_HEADER_NIBBLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) frame_err_reg <= 1'b0;
    else          frame_err_reg <= (state_reg == OUTPUT) && !hdr_ok;
  end

  assign frame_err = frame_err_reg;
`else
  assign hdr_ok    = 1'b1;
  assign frame_err = 1'b0;
`endif

  assign cs_n    = cs_n_reg;
  assign x       = x_reg;
  assign x_valid = x_valid_reg;
  assign status  = status_reg;
  assign overrun = overrun_reg;

endmodule
